// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receiver:
// transmitter state encoding, frame bit positions and a microsecond-to-cycle helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_FALL = 10;
  localparam int ACK_FALL  = 11;

  // Integer MHz assumed; the PS/2 timings are far coarser than any rounding here.
  function automatic int us_to_cyc(input int clk_hz, input int us);
    return (clk_hz / 1000000) * us;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte request channel and status of the PS/2 host transmitter.
// Handshake: a byte moves when tx_valid and tx_ready are both 1 on a rising clk edge;
// tx_ready is 1 only while the transmitter is idle, and a request made while busy is dropped.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;
  ps2_state_e state;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout_err, state
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout_err, state
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pads plus a registered
// falling-edge pulse of the synchronised clock; shared with the keyboard receiver.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key_clk_i,
  input  logic key_din_i,
  output logic clk_s_o,
  output logic din_s_o,
  output logic fall_o
);

  logic [1:0] clk_q;
  logic [1:0] din_q;
  logic       clk_prev_q;
  logic       fall_q;

  // Idle bus is high, so reset to 1 to avoid a spurious fall after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_q      <= 2'b11;
      din_q      <= 2'b11;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_q      <= {clk_q[0], key_clk_i};
      din_q      <= {din_q[0], key_din_i};
      clk_prev_q <= clk_q[1];
      fall_q     <= clk_prev_q & ~clk_q[1];
    end
  end

  assign clk_s_o = clk_q[1];
  assign din_s_o = din_q[1];
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send,
// shifts one command byte with odd parity, and checks the device ACK.
// Optional watchdog per transfer when PS2TX_TIMEOUT_EN is defined.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_clk,
  input  logic            key_din,
  output logic            key_clk_oe,
  output logic            key_din_oe,
  ps2_host_tx_if.slave    tx
);

  localparam int INHIBIT_CYC = us_to_cyc(CLK_HZ, INHIBIT_US);
  localparam int TIMEOUT_CYC = us_to_cyc(CLK_HZ, TIMEOUT_US);
`ifdef PS2TX_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam int LIMIT_MAX = (WD_EN && (TIMEOUT_CYC > INHIBIT_CYC)) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CNT_W     = (LIMIT_MAX > 1) ? $clog2(LIMIT_MAX) : 1;

  logic clk_s, din_s, fall;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_clk_i (key_clk),
    .key_din_i (key_din),
    .clk_s_o   (clk_s),
    .din_s_o   (din_s),
    .fall_o    (fall)
  );

  ps2_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [DATA_BITS:0]   shreg_q, shreg_d;
  logic                 din_oe_q, din_oe_d;
  logic                 ack_err_q, ack_err_d;
  logic                 tout_q, tout_d;
  logic                 start_early;
  logic                 done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      din_oe_q  <= 1'b0;
      ack_err_q <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      din_oe_q  <= din_oe_d;
      ack_err_q <= ack_err_d;
      tout_q    <= tout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    din_oe_d    = din_oe_q;
    ack_err_d   = ack_err_q;
    tout_d      = tout_q;
    start_early = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        din_oe_d = 1'b0;
        if (tx.tx_valid) begin
          shreg_d   = {~^tx.tx_data, tx.tx_data};
          ack_err_d = 1'b0;
          tout_d    = 1'b0;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        // Start bit goes low while the clock is still held, before release.
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
          start_early = 1'b1;
          din_oe_d    = 1'b1;
          cnt_d       = '0;
          state_d     = ST_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REQ: begin
        bitcnt_d = '0;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (fall) begin
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q + 4'd1 == 4'(STOP_FALL)) begin
            din_oe_d = 1'b0;
            state_d  = ST_ACK;
          end else begin
            din_oe_d = ~shreg_q[0];
            shreg_d  = shreg_q >> 1;
          end
        end
      end
      ST_ACK: begin
        if (fall) begin
          ack_err_d = din_s;
          bitcnt_d  = 4'(ACK_FALL);
          state_d   = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && din_s) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2TX_TIMEOUT_EN
    // Watchdog shares the cycle counter: it restarts at REQ entry.
    if (state_q != ST_IDLE && state_q != ST_INHIBIT) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        din_oe_d = 1'b0;
        tout_d   = 1'b1;
        done_c   = 1'b1;
        state_d  = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  assign key_clk_oe     = (state_q == ST_INHIBIT);
  assign key_din_oe     = din_oe_q | start_early;
  assign tx.tx_ready    = (state_q == ST_IDLE);
  assign tx.busy        = (state_q != ST_IDLE);
  assign tx.done        = done_c;
  assign tx.ack_err     = ack_err_q;
  assign tx.state       = state_q;
`ifdef PS2TX_TIMEOUT_EN
  assign tx.timeout_err = tout_q;
`else
  assign tx.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model on open-drain pads.
// Clock scaled to 5 MHz so INHIBIT is 500 cycles and a 40 us device clock is 200 cycles.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int CLK_HZ     = 5000000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_US = 2000;
  localparam int HALF       = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bfm_clk = 1'b1;
  logic bfm_din = 1'b1;
  logic key_clk, key_din, key_clk_oe, key_din_oe;

  assign key_clk = bfm_clk & ~key_clk_oe;
  assign key_din = bfm_din & ~key_din_oe;

  ps2_host_tx_if ifc ();

  ps2_host_tx #(
    .CLK_HZ     (CLK_HZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_clk    (key_clk),
    .key_din    (key_din),
    .key_clk_oe (key_clk_oe),
    .key_din_oe (key_din_oe),
    .tx         (ifc)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int acc_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (ifc.done === 1'b1) done_cnt++;
  always @(posedge clk) if (ifc.tx_valid === 1'b1 && ifc.tx_ready === 1'b1) acc_cnt++;

  // Device model: detects request, clocks nclk bits (sampling on rising edges), then ACKs.
  task automatic bfm_frame(input logic ack_bit, input int ack_hold, input int nclk,
                           output logic [10:0] fr);
    int n;
    fr = '1;
    n = 0;
    while (key_clk !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    while (!(key_clk === 1'b1 && key_din === 1'b0) && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL bfm_request: no request-to-send within %0d cycles", n);
      return;
    end
    fr[0] = key_din;
    for (int i = 1; i <= nclk; i++) begin
      repeat (HALF) @(negedge clk);
      bfm_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bfm_clk = 1'b1;
      fr[i] = key_din;
    end
    if (nclk == 10) begin
      repeat (HALF / 2) @(negedge clk);
      bfm_din = ack_bit;
      repeat (HALF / 2) @(negedge clk);
      bfm_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bfm_clk = 1'b1;
      repeat (ack_hold) @(negedge clk);
      bfm_din = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    ifc.tx_data  = d;
    ifc.tx_valid = 1'b1;
    @(negedge clk);
    ifc.tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int cyc;
    cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin @(negedge clk); cyc++; end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_clk_oe, key_din_oe} !== 2'b00) begin
      errors++; $display("FAIL reset_oe: got %b want 00", {key_clk_oe, key_din_oe});
    end
    checks++;
    if ({ifc.tx_ready, ifc.busy, ifc.done} !== 3'b100) begin
      errors++; $display("FAIL reset_hs: ready/busy/done got %b want 100", {ifc.tx_ready, ifc.busy, ifc.done});
    end
    checks++;
    if ({ifc.ack_err, ifc.timeout_err} !== 2'b00) begin
      errors++; $display("FAIL reset_err: got %b want 00", {ifc.ack_err, ifc.timeout_err});
    end
    checks++;
    if (ifc.state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", ifc.state, ST_IDLE);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_ed();
    logic [10:0] fr;
    int n, d0;
    d0 = done_cnt;
    fork
      bfm_frame(1'b0, 0, 10, fr);
      begin
        send(8'hED);
        checks++;
        if (key_clk_oe !== 1'b1) begin
          errors++; $display("FAIL ed_latency: key_clk_oe got %b want 1 one cycle after accept", key_clk_oe);
        end
        n = 0;
        while (key_clk_oe === 1'b1 && n < 5000) begin n++; @(negedge clk); end
        checks++;
        if (n != 500) begin
          errors++; $display("FAIL ed_inhibit: clock held %0d cycles want 500", n);
        end
      end
    join
    checks++;
    if (fr !== {2'b11, 8'hED, 1'b0}) begin
      errors++; $display("FAIL ed_frame: got %b want %b", fr, {2'b11, 8'hED, 1'b0});
    end
    wait_done(d0, 200, "ed_done");
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++; $display("FAIL ed_done_count: got %0d pulses want 1", done_cnt - d0);
    end
    checks++;
    if ({ifc.ack_err, ifc.tx_ready} !== 2'b01) begin
      errors++; $display("FAIL ed_status: ack_err/ready got %b want 01", {ifc.ack_err, ifc.tx_ready});
    end
  endtask

  task automatic test_nack_then_clear();
    logic [10:0] fr;
    int d0;
    d0 = done_cnt;
    fork
      bfm_frame(1'b1, 0, 10, fr);
      send(8'h01);
    join
    checks++;
    if (fr !== {2'b10, 8'h01, 1'b0}) begin
      errors++; $display("FAIL nack_frame: got %b want %b", fr, {2'b10, 8'h01, 1'b0});
    end
    wait_done(d0, 200, "nack_done");
    @(negedge clk);
    checks++;
    if (ifc.ack_err !== 1'b1) begin
      errors++; $display("FAIL nack_ack_err: got %b want 1", ifc.ack_err);
    end
    d0 = done_cnt;
    fork
      bfm_frame(1'b0, 0, 10, fr);
      begin
        send(8'hFF);
        checks++;
        if (ifc.ack_err !== 1'b0) begin
          errors++; $display("FAIL clear_on_accept: ack_err got %b want 0", ifc.ack_err);
        end
      end
    join
    checks++;
    if (fr !== {2'b11, 8'hFF, 1'b0}) begin
      errors++; $display("FAIL ff_frame: got %b want %b", fr, {2'b11, 8'hFF, 1'b0});
    end
    wait_done(d0, 200, "ff_done");
    @(negedge clk);
    checks++;
    if (ifc.ack_err !== 1'b0) begin
      errors++; $display("FAIL ff_ack_err: got %b want 0", ifc.ack_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] fr1, fr2;
    int a0, d0, n;
    a0 = acc_cnt;
    d0 = done_cnt;
    fork
      begin
        bfm_frame(1'b0, 0, 10, fr1);
        bfm_frame(1'b0, 0, 10, fr2);
      end
      begin
        @(negedge clk);
        ifc.tx_data  = 8'h55;
        ifc.tx_valid = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if ({ifc.tx_ready, ifc.busy} !== 2'b01) begin
          errors++; $display("FAIL b2b_busy: ready/busy got %b want 01", {ifc.tx_ready, ifc.busy});
        end
        n = 0;
        while (done_cnt == d0 && n < 5000) begin @(negedge clk); n++; end
        checks++;
        if (acc_cnt != a0 + 1) begin
          errors++; $display("FAIL b2b_single_accept: %0d accepts before done want 1", acc_cnt - a0);
        end
        n = 0;
        while (acc_cnt < a0 + 2 && n < 20) begin @(negedge clk); n++; end
        ifc.tx_valid = 1'b0;
      end
    join
    checks++;
    if (fr1 !== {2'b11, 8'h55, 1'b0}) begin
      errors++; $display("FAIL b2b_frame1: got %b want %b", fr1, {2'b11, 8'h55, 1'b0});
    end
    checks++;
    if (fr2 !== {2'b11, 8'h55, 1'b0}) begin
      errors++; $display("FAIL b2b_frame2: got %b want %b", fr2, {2'b11, 8'h55, 1'b0});
    end
    wait_done(d0 + 1, 200, "b2b_done2");
    repeat (10) @(negedge clk);
    checks++;
    if (acc_cnt != a0 + 2) begin
      errors++; $display("FAIL b2b_accepts: got %0d want 2", acc_cnt - a0);
    end
  endtask

  task automatic test_ack_hold();
    logic [10:0] fr;
    int d0;
    d0 = done_cnt;
    fork
      bfm_frame(1'b0, 5000, 10, fr);
      send(8'h12);
    join
    checks++;
    if (fr !== {2'b11, 8'h12, 1'b0}) begin
      errors++; $display("FAIL hold_frame: got %b want %b", fr, {2'b11, 8'h12, 1'b0});
    end
    checks++;
    if (done_cnt != d0 || ifc.busy !== 1'b1) begin
      errors++; $display("FAIL hold_early_done: pulses %0d busy %b want 0 and 1", done_cnt - d0, ifc.busy);
    end
    wait_done(d0, 10, "hold_done_after_idle");
  endtask

  task automatic test_reset_mid();
    logic [10:0] fr;
    int d0;
    fork
      bfm_frame(1'b0, 0, 4, fr);
      send(8'h0F);
    join
    checks++;
    if (fr[4:0] !== 5'b11110) begin
      errors++; $display("FAIL mid_partial_frame: got %b want 11110", fr[4:0]);
    end
    repeat (HALF) @(negedge clk);
    bfm_clk = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (key_din_oe !== 1'b1) begin
      errors++; $display("FAIL mid_d4_presented: key_din_oe got %b want 1", key_din_oe);
    end
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({key_clk_oe, key_din_oe} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_oe: got %b want 00", {key_clk_oe, key_din_oe});
    end
    checks++;
    if ({ifc.tx_ready, ifc.busy} !== 2'b10) begin
      errors++; $display("FAIL mid_reset_ready: ready/busy got %b want 10", {ifc.tx_ready, ifc.busy});
    end
    @(negedge clk);
    bfm_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt - d0);
    end
  endtask

  task automatic test_silent_device();
    int d0, n;
    d0 = done_cnt;
    send(8'hAB);
    n = 0;
`ifdef PS2TX_TIMEOUT_EN
    while (done_cnt == d0 && n < 12000) begin @(negedge clk); n++; end
    checks++;
    if (n < 10490 || n > 10510) begin
      errors++; $display("FAIL timeout_latency: done after %0d cycles want ~10500", n);
    end
    @(negedge clk);
    checks++;
    if ({key_clk_oe, key_din_oe, ifc.timeout_err, ifc.tx_ready} !== 4'b0011) begin
      errors++; $display("FAIL timeout_state: clk_oe/din_oe/tout/ready got %b want 0011",
                         {key_clk_oe, key_din_oe, ifc.timeout_err, ifc.tx_ready});
    end
`else
    while (done_cnt == d0 && n < 15000) begin @(negedge clk); n++; end
    checks++;
    if (done_cnt != d0 || ifc.busy !== 1'b1) begin
      errors++; $display("FAIL no_watchdog_busy: pulses %0d busy %b want 0 and 1", done_cnt - d0, ifc.busy);
    end
    checks++;
    if (ifc.timeout_err !== 1'b0) begin
      errors++; $display("FAIL no_watchdog_flag: timeout_err got %b want 0", ifc.timeout_err);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
`endif
  endtask

  initial begin
    ifc.tx_data  = 8'h00;
    ifc.tx_valid = 1'b0;
    test_reset();
    test_send_ed();
    test_nack_then_clear();
    test_back_to_back();
    test_ack_hold();
    test_reset_mid();
    test_silent_device();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
